// File: rtl/req_gnt_ctrl_pkg.sv
// Shared types and helpers for the req/gnt grant generator.
// Channel indices, ch1 FSM encoding, delay clamp.
package req_gnt_pkg;

  localparam int NUM_CH = 3;
  localparam int CH0    = 0;
  localparam int CH1    = 1;
  localparam int CH2    = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    WAIT  = 3'b010,
    GRANT = 3'b100
  } ch1_state_t;

  function automatic logic [2:0] clamp_dly(
    logic [2:0] d,
    int         lo,
    int         hi
  );
    logic [2:0] r;
    r = d;
    if (int'(d) < lo) r = 3'(lo);
    else if (int'(d) > hi) r = 3'(hi);
    return r;
  endfunction

endpackage

// File: rtl/req_gnt_ctrl_if.sv
// Requester-side req/gnt bundle for the 3-channel grant generator.
// master = requesters/observers, slave = grant generator.
interface req_gnt_ctrl_if
  import req_gnt_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic [NUM_CH-1:0] req;
  logic [2:0]        ch1_dly;
  logic [NUM_CH-1:0] gnt;
  logic              ch1_busy;
  logic              ch1_pending;
  logic [CNT_W-1:0]  ch1_drop_cnt;

  modport master (
    output req,
    output ch1_dly,
    input  gnt,
    input  ch1_busy,
    input  ch1_pending,
    input  ch1_drop_cnt
  );

  modport slave (
    input  req,
    input  ch1_dly,
    output gnt,
    output ch1_busy,
    output ch1_pending,
    output ch1_drop_cnt
  );

endinterface

// File: rtl/req_gnt_ctrl_dly_timer.sv
// Loadable 3-bit down-counter; expire flags the last wait cycle.
// Holds at zero once run out.
module req_gnt_dly_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       expire
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 3'd0;
    else          cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == 3'd1);

endmodule

// File: rtl/req_gnt_ctrl.sv
// 3-channel grant generator: ch0 1-cycle, ch1 3..5-cycle w/ pending, ch2 comb.
// Define REQ_GNT_ASSERT_EN to embed the req/gnt protocol properties.
module req_gnt_ctrl
  import req_gnt_pkg::*;
#(
  parameter int CH1_MIN_DLY = 3,
  parameter int CH1_MAX_DLY = 5,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            reset_n,
  req_gnt_ctrl_if.slave  bus
);

  logic [NUM_CH-1:0] req_q, req_d;
  logic              active_q, active_d;
  logic              gnt0_q, gnt0_d;
  ch1_state_t        state_q, state_d;
  logic              pend_q, pend_d;
  logic [2:0]        pend_dly_q, pend_dly_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [NUM_CH-1:0] rise;
  logic [2:0]        dly_c;
  logic              t_load;
  logic [2:0]        t_val;
  logic              t_en;
  logic              t_exp;

  assign rise  = bus.req & ~req_q;
  assign dly_c = clamp_dly(bus.ch1_dly, CH1_MIN_DLY, CH1_MAX_DLY);

  assign req_d    = bus.req;
  assign active_d = 1'b1;
  assign gnt0_d   = rise[CH0] & active_q;
  assign t_en     = (state_q == WAIT);

  req_gnt_dly_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .expire   (t_exp)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_dly_d = pend_dly_q;
    drop_d     = drop_q;
    t_load     = 1'b0;
    t_val      = dly_c - 3'd1;
    unique case (state_q)
      IDLE: begin
        if (rise[CH1]) begin
          t_load  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (t_exp) state_d = GRANT;
        if (rise[CH1]) begin
          if (pend_q) begin
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          end else begin
            pend_d     = 1'b1;
            pend_dly_d = dly_c;
          end
        end
      end
      GRANT: begin
        // stored request restarts; a same-cycle rise takes its slot
        if (pend_q) begin
          t_load  = 1'b1;
          t_val   = pend_dly_q - 3'd1;
          state_d = WAIT;
          if (rise[CH1]) pend_dly_d = dly_c;
          else           pend_d     = 1'b0;
        end else if (rise[CH1]) begin
          t_load  = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= '0;
      active_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_dly_q <= 3'd0;
      drop_q     <= '0;
    end else begin
      req_q      <= req_d;
      active_q   <= active_d;
      gnt0_q     <= gnt0_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_dly_q <= pend_dly_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.gnt[CH0]     = gnt0_q;
  assign bus.gnt[CH1]     = (state_q == GRANT) & active_q;
  assign bus.gnt[CH2]     = bus.req[CH2] & active_q;
  assign bus.ch1_busy     = (state_q == WAIT) | (state_q == GRANT);
  assign bus.ch1_pending  = pend_q;
  assign bus.ch1_drop_cnt = drop_q;

`ifdef REQ_GNT_ASSERT_EN
  a_ch0: assert property (@(posedge clk) disable iff (!reset_n)
    ($rose(bus.req[CH0]) && active_q) |=> bus.gnt[CH0]);

  a_ch1: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE && rise[CH1])
      |-> ##[CH1_MIN_DLY:CH1_MAX_DLY] bus.gnt[CH1]);

  a_ch2: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.req[CH2] && active_q) |-> bus.gnt[CH2]);

  a_fsm: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(state_q));

  a_g1: assert property (@(posedge clk) disable iff (!reset_n)
    bus.gnt[CH1] |=> !bus.gnt[CH1]);
`endif

endmodule

// File: tb/tb_req_gnt_ctrl.sv
// Bench for req_gnt_ctrl: directed vector table, reset corners,
// randomized streams against a time-based reference model.
module tb_req_gnt_ctrl;

  logic clk;
  logic reset_n;

  req_gnt_ctrl_if #(.CNT_W(8)) bus ();

  req_gnt_ctrl #(
    .CH1_MIN_DLY (3),
    .CH1_MAX_DLY (5),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] req;
    logic [2:0] dly;
    logic [2:0] gnt;
    logic       busy;
    logic       pend;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[21];

  // reference model: ch1 grant tracked as the absolute edge index
  int   k;
  int   g;
  bit   gv;
  bit   pv;
  int   pd;
  int   drop;
  bit   act;
  logic [2:0] rq;
  bit   g0;

  logic [2:0] e_gnt;
  logic       e_busy;
  logic       e_pend;
  logic [7:0] e_drop;

  function automatic int clampd(int d);
    if (d < 3) return 3;
    if (d > 5) return 5;
    return d;
  endfunction

  task automatic model_reset();
    k = 0; g = 0; gv = 0; pv = 0; pd = 0;
    drop = 0; act = 0; rq = 3'b000; g0 = 0;
  endtask

  task automatic model_edge(input logic [2:0] r,
                            input logic [2:0] d);
    logic [2:0] rs;
    bit bprev, ingr;
    int dd;
    k++;
    rs    = r & ~rq;
    bprev = gv && (g >= k - 1);
    ingr  = gv && (g == k - 1);
    dd    = clampd(int'(d));
    g0    = rs[0] & act;
    if (rs[1]) begin
      if (!bprev) begin
        g = k + dd - 1; gv = 1;
      end else if (ingr) begin
        if (pv) begin
          g = k + pd - 1; pd = dd;
        end else begin
          g = k + dd - 1;
        end
      end else if (pv) begin
        if (drop < 255) drop++;
      end else begin
        pv = 1; pd = dd;
      end
    end else if (ingr && pv) begin
      g = k + pd - 1; pv = 0;
    end
    rq  = r;
    act = 1;
    e_gnt  = {r[2] & act, act && gv && (g == k), g0};
    e_busy = gv && (g >= k);
    e_pend = pv;
    e_drop = 8'(drop);
  endtask

  task automatic chk(input string nm,
                     input logic [2:0] eg,
                     input logic eb,
                     input logic ep,
                     input logic [7:0] ed);
    checks++;
    if (bus.gnt !== eg || bus.ch1_busy !== eb ||
        bus.ch1_pending !== ep || bus.ch1_drop_cnt !== ed) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b busy=%b pend=%b drop=%0d want gnt=%b busy=%b pend=%b drop=%0d",
               nm, $time, bus.gnt, bus.ch1_busy, bus.ch1_pending,
               bus.ch1_drop_cnt, eg, eb, ep, ed);
    end
  endtask

  task automatic step_model(input string nm,
                            input logic [2:0] r,
                            input logic [2:0] d);
    bus.req = r;
    bus.ch1_dly = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    chk(nm, e_gnt, e_busy, e_pend, e_drop);
  endtask

  task automatic fill_tbl();
    tbl[0]  = '{3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{3'b001, 3'd0, 3'b001, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{3'b001, 3'd0, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{3'b001, 3'd0, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{3'b100, 3'd0, 3'b100, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{3'b100, 3'd0, 3'b100, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{3'b010, 3'd4, 3'b000, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{3'b000, 3'd4, 3'b000, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{3'b010, 3'd7, 3'b000, 1'b1, 1'b1, 8'd0};
    tbl[11] = '{3'b000, 3'd0, 3'b010, 1'b1, 1'b1, 8'd0};
    tbl[12] = '{3'b010, 3'd0, 3'b000, 1'b1, 1'b1, 8'd0};
    tbl[13] = '{3'b000, 3'd0, 3'b000, 1'b1, 1'b1, 8'd0};
    tbl[14] = '{3'b010, 3'd2, 3'b000, 1'b1, 1'b1, 8'd1};
    tbl[15] = '{3'b000, 3'd0, 3'b000, 1'b1, 1'b1, 8'd1};
    tbl[16] = '{3'b000, 3'd0, 3'b010, 1'b1, 1'b1, 8'd1};
    tbl[17] = '{3'b000, 3'd0, 3'b000, 1'b1, 1'b0, 8'd1};
    tbl[18] = '{3'b000, 3'd0, 3'b000, 1'b1, 1'b0, 8'd1};
    tbl[19] = '{3'b100, 3'd0, 3'b110, 1'b1, 1'b0, 8'd1};
    tbl[20] = '{3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 8'd1};
  endtask

  initial begin
    fill_tbl();
    reset_n     = 1'b0;
    bus.req     = 3'b000;
    bus.ch1_dly = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 3'b000, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b1;
    model_reset();

    // directed table: ch0 edge, ch2 level, ch1 delay/pending/drop
    for (int i = 0; i < 21; i++) begin
      bus.req     = tbl[i].req;
      bus.ch1_dly = tbl[i].dly;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].busy,
          tbl[i].pend, tbl[i].drop);
    end

    // reset during ch1 WAIT with ch2 asserted
    bus.req = 3'b010; bus.ch1_dly = 3'd5;
    @(posedge clk); #1;
    bus.req = 3'b100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset", 3'b100, 1'b1, 1'b0, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset", 3'b000, 1'b0, 1'b0, 8'd0);
    bus.req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    bus.req = 3'b101;
    #1;
    chk("inactive_gnt2", 3'b000, 1'b0, 1'b0, 8'd0);
    step_model("first_edge", 3'b101, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step_model("post_reset", 3'b000, 3'd0);
    end

    // random streams
    for (int i = 0; i < 3000; i++) begin
      step_model("random", 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
    end

    // drop counter saturation
    for (int i = 0; i < 2000; i++) begin
      step_model("saturate", (i % 2 == 0) ? 3'b010 : 3'b000, 3'd7);
    end
    chk("drop_sat", e_gnt, e_busy, e_pend, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
